// File: rtl/arcade_input_mapper_pkg.sv
// Shared definitions for the arcade input mapper: scancodes, rotation modes,
// joystick bit layout and the combinational rotation/SOCD stage.
package arcade_input_pkg;

    typedef enum logic [1:0] {ROT_0, ROT_CW, ROT_180, ROT_CCW} rot_t;

    // {extended, scancode}
    localparam logic [8:0] SC_UP     = 9'h175;
    localparam logic [8:0] SC_DOWN   = 9'h172;
    localparam logic [8:0] SC_LEFT   = 9'h16B;
    localparam logic [8:0] SC_RIGHT  = 9'h174;
    localparam logic [8:0] SC_START1 = 9'h005;
    localparam logic [8:0] SC_START2 = 9'h006;
    localparam logic [8:0] SC_FIRE0  = 9'h014;
    localparam logic [8:0] SC_FIRE1  = 9'h011;
    localparam logic [8:0] SC_FIRE2  = 9'h029;
    localparam logic [8:0] SC_FIRE3  = 9'h012;
    localparam logic [8:0] SC_COIN1  = 9'h02E;
    localparam logic [8:0] SC_COIN2  = 9'h036;

    function automatic int unsigned start_bit(int unsigned buttons);
        return 4 + buttons;
    endfunction

    function automatic int unsigned coin_bit(int unsigned buttons);
        return 5 + buttons;
    endfunction

    // Keyboard fire key -> button index; 8 means "not a fire key"
    function automatic int unsigned fire_index(logic [8:0] code);
        int unsigned idx;
        case (code)
            SC_FIRE0: idx = 0;
            SC_FIRE1: idx = 1;
            SC_FIRE2: idx = 2;
            SC_FIRE3: idx = 3;
            default:  idx = 8;
        endcase
        return idx;
    endfunction

    // d and result are {U,D,L,R}; rotation maps physical to logical, then SOCD
    function automatic logic [3:0] map_dir(logic [3:0] d, rot_t rot, logic neutral);
        logic [3:0] r;
        case (rot)
            ROT_CW:  r = {d[1], d[0], d[2], d[3]};
            ROT_180: r = {d[2], d[3], d[0], d[1]};
            ROT_CCW: r = {d[0], d[1], d[3], d[2]};
            default: r = d;
        endcase
        if (neutral) begin
            if (r[3] && r[2]) r[3:2] = '0;
            if (r[1] && r[0]) r[1:0] = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Bundle of hps_io-side inputs and game-core-side outputs of the input mapper.
interface arcade_input_mapper_if #(
    parameter int unsigned BUTTONS = 2
);
    logic [10:0]        ps2_key;
    logic [15:0]        joystick_0;
    logic [15:0]        joystick_1;
    logic               vblank;
    logic [1:0]         rotate;
    logic [BUTTONS-1:0] autofire_en;
    logic [3:0]         p1_dir;
    logic [3:0]         p2_dir;
    logic [BUTTONS-1:0] p1_btn;
    logic [BUTTONS-1:0] p2_btn;
    logic [1:0]         start;
    logic [1:0]         coin;

    modport master (
        output ps2_key, joystick_0, joystick_1, vblank, rotate, autofire_en,
        input  p1_dir, p2_dir, p1_btn, p2_btn, start, coin
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1, vblank, rotate, autofire_en,
        output p1_dir, p2_dir, p1_btn, p2_btn, start, coin
    );
endinterface

// File: rtl/arcade_input_mapper_coin_pulser.sv
// Fixed-width coin pulse: rising edge of the (registered) request loads a
// down-counter; edges arriving while the counter runs are dropped.
module coin_pulser #(
    parameter int unsigned COIN_PULSE = 50000
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic req,
    output logic pulse
);
    localparam int unsigned TW = $clog2(COIN_PULSE + 1);

    logic [TW-1:0] timer;
    logic          req_q;
    logic          req_qq;

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            req_q  <= 1'b0;
            req_qq <= 1'b0;
            timer  <= '0;
        end else begin
            req_q  <= req;
            req_qq <= req_q;
            if (timer != '0)
                timer <= timer - TW'(1);
            else if (req_q && !req_qq)
                timer <= TW'(COIN_PULSE);
        end
    end

    assign pulse = (timer != '0);
endmodule

// File: rtl/arcade_input_mapper.sv
// Player-input front end: merges PS/2 keys and joysticks, applies rotation,
// SOCD cleaning, vblank-timed autofire and fixed-width coin pulses.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int unsigned PLAYERS       = 2,
    parameter int unsigned BUTTONS       = 2,
    parameter int unsigned COIN_PULSE    = 50000,
    parameter bit          COIN_ON_START = 1'b1,
    parameter int unsigned AF_FRAMES     = 4,
    parameter bit          SOCD_NEUTRAL  = 1'b1
) (
    input  logic                  clk_sys,
    input  logic                  RESET,
    arcade_input_mapper_if.slave  io
);
    localparam int unsigned SB  = start_bit(BUTTONS);
    localparam int unsigned CB  = coin_bit(BUTTONS);
    localparam int unsigned AFW = ($clog2(AF_FRAMES) > 0) ? $clog2(AF_FRAMES) : 1;

    logic               ps2_tog;
    logic               ps2_event;
    logic [8:0]         ps2_code;
    logic               pressed;
    logic [3:0]         key_dir;
    logic [1:0]         key_start;
    logic [1:0]         key_coin;
    logic [BUTTONS-1:0] key_btn;

    assign ps2_event = (io.ps2_key[10] != ps2_tog);
    assign ps2_code  = io.ps2_key[8:0];
    assign pressed   = io.ps2_key[9];

    // Tracker is reloaded during reset so a toggle seen there never becomes an event
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            ps2_tog   <= io.ps2_key[10];
            key_dir   <= '0;
            key_start <= '0;
            key_coin  <= '0;
            key_btn   <= '0;
        end else if (ps2_event) begin
            ps2_tog <= io.ps2_key[10];
            case (ps2_code)
                SC_UP:     key_dir[3]   <= pressed;
                SC_DOWN:   key_dir[2]   <= pressed;
                SC_LEFT:   key_dir[1]   <= pressed;
                SC_RIGHT:  key_dir[0]   <= pressed;
                SC_START1: key_start[0] <= pressed;
                SC_START2: key_start[1] <= pressed;
                SC_COIN1:  key_coin[0]  <= pressed;
                SC_COIN2:  key_coin[1]  <= pressed;
                default: ;
            endcase
            for (int unsigned i = 0; i < BUTTONS; i++)
                if (fire_index(ps2_code) == i) key_btn[i] <= pressed;
        end
    end

    logic [15:0]        p1_joy;
    logic [15:0]        p2_joy;
    logic [3:0]         raw1_dir;
    logic [3:0]         raw2_dir;
    logic [BUTTONS-1:0] held1;
    logic [BUTTONS-1:0] held2;
    logic [1:0]         start_req;
    logic [1:0]         coin_req;
    logic               unused_joy;

    // Single-player cabinets fold the second joystick into P1
    always_comb begin
        p1_joy       = io.joystick_0 | ((PLAYERS == 1) ? io.joystick_1 : '0);
        p2_joy       = (PLAYERS == 1) ? '0 : io.joystick_1;
        raw1_dir     = key_dir | p1_joy[3:0];
        raw2_dir     = p2_joy[3:0];
        held1        = key_btn | p1_joy[4 +: BUTTONS];
        held2        = p2_joy[4 +: BUTTONS];
        start_req[0] = key_start[0] | p1_joy[SB];
        start_req[1] = key_start[1] | p2_joy[SB];
        coin_req[0]  = key_coin[0] | p1_joy[CB] | (COIN_ON_START & start_req[0]);
        coin_req[1]  = key_coin[1] | p2_joy[CB] | (COIN_ON_START & start_req[1]);
    end

    assign unused_joy = ^{io.joystick_0[15:CB+1], io.joystick_1[15:CB+1]};

    logic           vblank_q;
    logic [AFW-1:0] af_count;
    logic           af_phase;

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            vblank_q <= 1'b0;
            af_count <= '0;
            af_phase <= 1'b1;
        end else begin
            vblank_q <= io.vblank;
            if (io.vblank && !vblank_q) begin
                if (af_count == AFW'(AF_FRAMES - 1)) begin
                    af_count <= '0;
                    af_phase <= ~af_phase;
                end else begin
                    af_count <= af_count + AFW'(1);
                end
            end
        end
    end

    logic [BUTTONS-1:0] fire_gate;
    assign fire_gate = ~io.autofire_en | {BUTTONS{af_phase}};

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            io.p1_dir <= '0;
            io.p2_dir <= '0;
            io.p1_btn <= '0;
            io.p2_btn <= '0;
            io.start  <= '0;
        end else begin
            io.p1_dir <= map_dir(raw1_dir, rot_t'(io.rotate), SOCD_NEUTRAL);
            io.p2_dir <= map_dir(raw2_dir, rot_t'(io.rotate), SOCD_NEUTRAL);
            io.p1_btn <= held1 & fire_gate;
            io.p2_btn <= held2 & fire_gate;
            io.start  <= start_req;
        end
    end

    logic coin0;
    logic coin1;

    coin_pulser #(.COIN_PULSE(COIN_PULSE)) u_coin0 (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .req     (coin_req[0]),
        .pulse   (coin0)
    );

    coin_pulser #(.COIN_PULSE(COIN_PULSE)) u_coin1 (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .req     (coin_req[1]),
        .pulse   (coin1)
    );

    assign io.coin = {coin1, coin0};
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Two mapper configurations driven by shared directed + random stimulus,
// every output compared each cycle against a behavioural model.
module tb_arcade_input_mapper;

    localparam int unsigned A_PLAYERS = 2, A_PULSE = 8, A_AF = 2;
    localparam bit          A_COS = 1'b0, A_SOCD = 1'b1;
    localparam int unsigned B_PLAYERS = 1, B_PULSE = 5, B_AF = 3;
    localparam bit          B_COS = 1'b1, B_SOCD = 1'b0;

    logic        clk_sys = 1'b0;
    logic        RESET;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        vblank;
    logic [1:0]  rotate;
    logic [1:0]  autofire_en;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper_if #(.BUTTONS(2)) ifa ();
    arcade_input_mapper_if #(.BUTTONS(2)) ifb ();

    assign ifa.ps2_key = ps2_key;     assign ifb.ps2_key = ps2_key;
    assign ifa.joystick_0 = joystick_0; assign ifb.joystick_0 = joystick_0;
    assign ifa.joystick_1 = joystick_1; assign ifb.joystick_1 = joystick_1;
    assign ifa.vblank = vblank;       assign ifb.vblank = vblank;
    assign ifa.rotate = rotate;       assign ifb.rotate = rotate;
    assign ifa.autofire_en = autofire_en; assign ifb.autofire_en = autofire_en;

    arcade_input_mapper #(
        .PLAYERS(A_PLAYERS), .BUTTONS(2), .COIN_PULSE(A_PULSE),
        .COIN_ON_START(A_COS), .AF_FRAMES(A_AF), .SOCD_NEUTRAL(A_SOCD)
    ) dut_a (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .io      (ifa)
    );

    arcade_input_mapper #(
        .PLAYERS(B_PLAYERS), .BUTTONS(2), .COIN_PULSE(B_PULSE),
        .COIN_ON_START(B_COS), .AF_FRAMES(B_AF), .SOCD_NEUTRAL(B_SOCD)
    ) dut_b (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .io      (ifb)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Model state: set of currently held keys, vblank edges since reset, coin history
    bit          kb        [2][512];
    int unsigned vb_edges  [2];
    bit          vb_prev   [2];
    bit          prev_tog  [2];
    bit          req_h1    [2][2];
    bit          req_h2    [2][2];
    bit          coin_prev [2][2];
    int unsigned coin_left [2][2];

    function automatic logic [8:0] fire_code(input int b);
        return (b == 0) ? 9'h014 : 9'h011;
    endfunction

    task automatic check_dut(input int k, input logic [3:0] g_d1, input logic [3:0] g_d2,
                             input logic [1:0] g_b1, input logic [1:0] g_b2,
                             input logic [1:0] g_st, input logic [1:0] g_cn);
        int unsigned players, pulse_len, af;
        bit          cos, socd, phase, kp, held;
        bit          phys [4];
        bit          lg   [4];
        logic [15:0] pj;
        logic [3:0]  e_dir [2];
        logic [1:0]  e_btn [2];
        logic [1:0]  e_start, e_coin;
        bit          req;
        string       nm;
        players   = (k == 0) ? A_PLAYERS : B_PLAYERS;
        pulse_len = (k == 0) ? A_PULSE : B_PULSE;
        af        = (k == 0) ? A_AF : B_AF;
        cos       = (k == 0) ? A_COS : B_COS;
        socd      = (k == 0) ? A_SOCD : B_SOCD;
        nm        = (k == 0) ? "A" : "B";
        e_dir[0] = '0; e_dir[1] = '0; e_btn[0] = '0; e_btn[1] = '0;
        e_start = '0; e_coin = '0;
        if (RESET) begin
            for (int i = 0; i < 512; i++) kb[k][i] = 1'b0;
            vb_edges[k] = 0;
            vb_prev[k]  = 1'b0;
            for (int p = 0; p < 2; p++) begin
                req_h1[k][p] = 0; req_h2[k][p] = 0; coin_prev[k][p] = 0; coin_left[k][p] = 0;
            end
        end else begin
            phase = ((vb_edges[k] / af) % 2) == 0;
            for (int p = 0; p < 2; p++) begin
                if (p == 0) pj = joystick_0 | ((players == 1) ? joystick_1 : 16'h0);
                else        pj = (players == 2) ? joystick_1 : 16'h0;
                kp = (p == 0);
                // compass order U, R, D, L; rotation n reads the physical direction n steps back
                phys[0] = pj[3] | (kp & kb[k][9'h175]);
                phys[1] = pj[0] | (kp & kb[k][9'h174]);
                phys[2] = pj[2] | (kp & kb[k][9'h172]);
                phys[3] = pj[1] | (kp & kb[k][9'h16B]);
                for (int i = 0; i < 4; i++) lg[i] = phys[(i + 4 - int'(rotate)) % 4];
                if (socd && lg[0] && lg[2]) begin lg[0] = 0; lg[2] = 0; end
                if (socd && lg[1] && lg[3]) begin lg[1] = 0; lg[3] = 0; end
                e_dir[p] = {lg[0], lg[2], lg[3], lg[1]};
                for (int b = 0; b < 2; b++) begin
                    held = pj[4+b] | (kp & kb[k][fire_code(b)]);
                    e_btn[p][b] = held & (autofire_en[b] ? phase : 1'b1);
                end
                e_start[p] = pj[6] | kb[k][(p == 0) ? 9'h005 : 9'h006];
                req = pj[7] | kb[k][(p == 0) ? 9'h02E : 9'h036] | (cos & e_start[p]);
                if (req_h1[k][p] && !req_h2[k][p] && !coin_prev[k][p]) coin_left[k][p] = pulse_len;
                e_coin[p] = (coin_left[k][p] != 0);
                if (coin_left[k][p] != 0) coin_left[k][p]--;
                coin_prev[k][p] = e_coin[p];
                req_h2[k][p] = req_h1[k][p];
                req_h1[k][p] = req;
            end
            if (ps2_key[10] != prev_tog[k]) kb[k][ps2_key[8:0]] = ps2_key[9];
            if (vblank && !vb_prev[k]) vb_edges[k]++;
            vb_prev[k] = vblank;
        end
        prev_tog[k] = ps2_key[10];
        check({nm, ".p1_dir"}, 16'(g_d1), 16'(e_dir[0]));
        check({nm, ".p2_dir"}, 16'(g_d2), 16'(e_dir[1]));
        check({nm, ".p1_btn"}, 16'(g_b1), 16'(e_btn[0]));
        check({nm, ".p2_btn"}, 16'(g_b2), 16'(e_btn[1]));
        check({nm, ".start"},  16'(g_st), 16'(e_start));
        check({nm, ".coin"},   16'(g_cn), 16'(e_coin));
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        check_dut(0, ifa.p1_dir, ifa.p2_dir, ifa.p1_btn, ifa.p2_btn, ifa.start, ifa.coin);
        check_dut(1, ifb.p1_dir, ifb.p2_dir, ifb.p1_btn, ifb.p2_btn, ifb.start, ifb.coin);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_key(input logic [8:0] code, input logic down);
        ps2_key = {~ps2_key[10], down, code};
    endtask

    function automatic logic [8:0] pick_code(input int n);
        logic [8:0] c;
        case (n)
            0: c = 9'h175;  1: c = 9'h172;  2: c = 9'h16B;  3: c = 9'h174;
            4: c = 9'h005;  5: c = 9'h006;  6: c = 9'h014;  7: c = 9'h011;
            8: c = 9'h029;  9: c = 9'h012; 10: c = 9'h02E; 11: c = 9'h036;
            12: c = 9'h075; default: c = 9'h01C;
        endcase
        return c;
    endfunction

    initial begin
        int unsigned rst_left;
        int unsigned idx;
        RESET = 1'b1; ps2_key = '0; joystick_0 = '0; joystick_1 = '0;
        vblank = 1'b0; rotate = 2'd0; autofire_en = 2'b00;

        // key toggles during reset must not latch anything
        for (int i = 0; i < 4; i++) begin
            send_key(9'h175, 1'b1);
            tick();
        end
        RESET = 1'b0;
        ticks(3);

        send_key(9'h175, 1'b1); ticks(4);
        rotate = 2'd1;           ticks(3);
        send_key(9'h175, 1'b0); ticks(3);
        rotate = 2'd0;

        joystick_0 = 16'h000C; ticks(3);
        joystick_0 = 16'h0000; ticks(2);

        joystick_0[7] = 1'b1; ticks(20);
        joystick_0[7] = 1'b0; ticks(12);
        joystick_0[7] = 1'b1; tick();
        joystick_0[7] = 1'b0; ticks(3);
        joystick_0[7] = 1'b1; ticks(15);
        joystick_0[7] = 1'b0; ticks(4);

        autofire_en = 2'b01;
        send_key(9'h014, 1'b1);
        for (int f = 0; f < 8; f++) begin
            vblank = 1'b1; ticks(2);
            vblank = 1'b0; ticks(3);
        end
        autofire_en = 2'b00; ticks(4);
        send_key(9'h014, 1'b0); ticks(3);

        joystick_1[6] = 1'b1; ticks(12);
        joystick_1[6] = 1'b0; ticks(8);

        // mid-pulse reset
        joystick_1[7] = 1'b1; ticks(4);
        RESET = 1'b1; tick();
        RESET = 1'b0; joystick_1[7] = 1'b0; ticks(4);

        rst_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (rst_left != 0) begin
                RESET = 1'b1;
                rst_left--;
                ps2_key[10] = 1'($urandom_range(0, 1));
            end else begin
                RESET = 1'b0;
                if ($urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 5) == 0)
                send_key(pick_code(int'($urandom_range(0, 13))), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 6) == 0) begin
                idx = $urandom_range(0, 7);
                joystick_0[idx] = ~joystick_0[idx];
            end
            if ($urandom_range(0, 6) == 0) begin
                idx = $urandom_range(0, 7);
                joystick_1[idx] = ~joystick_1[idx];
            end
            if ($urandom_range(0, 99) == 0) begin
                idx = $urandom_range(8, 15);
                joystick_0[idx] = ~joystick_0[idx];
            end
            vblank = (cyc % 7) < 2;
            if ($urandom_range(0, 59) == 0) rotate = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) autofire_en = 2'($urandom_range(0, 3));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
